// File: rtl/hangman_engine.sv
// hangman_engine: one-game hangman controller. Guesses arrive over a
// valid/ready handshake, the secret word is scanned one position per clock,
// and a one-cycle coded result is returned. A loss triggers a sequential
// reveal-all sweep before the engine parks in LOSE.
//
// Handshake: a guess transfers on a rising edge where guess_valid and
// guess_ready are both 1; guess_ready is high only in WAIT with no new_game,
// and guess_valid while not ready is dropped, never queued.
module hangman_engine #(
  parameter int MAX_LEN    = 12,
  parameter int CHAR_W     = 8,
  parameter int MAX_MISSES = 6,
  parameter int LEN_W      = $clog2(MAX_LEN + 1),
  parameter int MISS_W     = $clog2(MAX_MISSES + 1)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         new_game,
  input  logic [MAX_LEN*CHAR_W-1:0]    word,
  input  logic [LEN_W-1:0]             length,
  input  logic                         guess_valid,
  input  logic [CHAR_W-1:0]            guess,
  output logic                         guess_ready,
  output logic                         result_valid,
  output logic [1:0]                   result_code,
  output logic [MAX_LEN*CHAR_W-1:0]    revealed,
  output logic [MAX_LEN-1:0]           revealed_mask,
  output logic [MAX_MISSES*CHAR_W-1:0] missed,
  output logic [MISS_W-1:0]            miss_count,
  output logic                         win,
  output logic                         lose,
  output logic                         busy,
  output logic [2:0]                   dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_SCAN    = 3'd2;
  localparam logic [2:0] S_RESOLVE = 3'd3;
  localparam logic [2:0] S_SWEEP   = 3'd4;
  localparam logic [2:0] S_WIN     = 3'd5;
  localparam logic [2:0] S_LOSE    = 3'd6;

  localparam logic [1:0] C_HIT    = 2'b00;
  localparam logic [1:0] C_MISS   = 2'b01;
  localparam logic [1:0] C_REPEAT = 2'b10;
  localparam logic [1:0] C_REJECT = 2'b11;

  logic [2:0]                   r_state;
  logic [MAX_LEN*CHAR_W-1:0]    r_word;
  logic [LEN_W-1:0]             r_len;
  logic [MAX_LEN-1:0]           r_mask;
  logic [MAX_MISSES*CHAR_W-1:0] r_missed;
  logic [MISS_W-1:0]            r_miss_count;
  logic [CHAR_W-1:0]            r_guess;
  logic [LEN_W-1:0]             r_idx;
  logic                         r_new;
  logic                         r_repeat;
  logic                         r_reject;

  logic [CHAR_W-1:0]            w_cur_char;
  logic                         w_cur_mask;
  logic [MAX_LEN-1:0]           w_idx_onehot;
  logic [MAX_LEN-1:0]           w_len_mask;
  logic [MAX_MISSES*CHAR_W-1:0] w_slot_fill;
  logic                         w_miss_repeat;
  logic                         w_last;
  logic                         w_all_revealed;
  logic                         w_len_ok;
  logic [1:0]                   w_code;
  logic [MISS_W-1:0]            w_miss_inc;
  logic                         w_lose_next;

  // Select the character and mask bit under the scan/sweep index, and build
  // the mask of positions that belong to the current word.
  always_comb begin
    w_cur_char   = '0;
    w_cur_mask   = 1'b0;
    w_idx_onehot = '0;
    w_len_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (r_idx == LEN_W'(i)) begin
        w_cur_char      = r_word[i*CHAR_W +: CHAR_W];
        w_cur_mask      = r_mask[i];
        w_idx_onehot[i] = 1'b1;
      end
      if (LEN_W'(i) < r_len) w_len_mask[i] = 1'b1;
    end
  end

  // Previously missed letters: match against the incoming guess, and the
  // next free slot for the latched guess.
  always_comb begin
    w_miss_repeat = 1'b0;
    w_slot_fill   = '0;
    for (int k = 0; k < MAX_MISSES; k++) begin
      if ((MISS_W'(k) < r_miss_count) && (r_missed[k*CHAR_W +: CHAR_W] == guess))
        w_miss_repeat = 1'b1;
      if (MISS_W'(k) == r_miss_count)
        w_slot_fill[k*CHAR_W +: CHAR_W] = r_guess;
    end
  end

  // Result priority: reject, then a fresh hit, then repeat, else miss.
  always_comb begin
    w_code = C_MISS;
    if (r_reject)      w_code = C_REJECT;
    else if (r_new)    w_code = C_HIT;
    else if (r_repeat) w_code = C_REPEAT;
  end

  assign w_last         = (r_idx == (r_len - LEN_W'(1)));
  assign w_all_revealed = ((r_mask & w_len_mask) == w_len_mask);
  assign w_len_ok       = (length != '0) && (length <= LEN_W'(MAX_LEN));
  assign w_miss_inc     = r_miss_count + MISS_W'(1);
  assign w_lose_next    = (w_code == C_MISS) && (w_miss_inc == MISS_W'(MAX_MISSES));

  // Game FSM and all game state; new_game overrides whatever is in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_len        <= '0;
      r_mask       <= '0;
      r_missed     <= '0;
      r_miss_count <= '0;
      r_guess      <= '0;
      r_idx        <= '0;
      r_new        <= 1'b0;
      r_repeat     <= 1'b0;
      r_reject     <= 1'b0;
    end else if (new_game) begin
      r_word       <= word;
      r_len        <= length;
      r_mask       <= '0;
      r_missed     <= '0;
      r_miss_count <= '0;
      r_idx        <= '0;
      r_new        <= 1'b0;
      r_repeat     <= 1'b0;
      r_reject     <= 1'b0;
      r_state      <= w_len_ok ? S_WAIT : S_IDLE;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (guess_valid) begin
            r_guess  <= guess;
            r_idx    <= '0;
            r_new    <= 1'b0;
            r_repeat <= w_miss_repeat;
            r_reject <= (guess == '0);
            r_state  <= (guess == '0) ? S_RESOLVE : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_cur_char == r_guess) begin
            if (w_cur_mask) begin
              r_repeat <= 1'b1;
            end else begin
              r_mask <= r_mask | w_idx_onehot;
              r_new  <= 1'b1;
            end
          end
          if (w_last) r_state <= S_RESOLVE;
          else        r_idx   <= r_idx + LEN_W'(1);
        end
        S_RESOLVE: begin
          if ((w_code == C_MISS) && (r_miss_count != MISS_W'(MAX_MISSES))) begin
            r_missed     <= r_missed | w_slot_fill;
            r_miss_count <= w_miss_inc;
          end
          r_idx <= '0;
          if (w_all_revealed)   r_state <= S_WIN;
          else if (w_lose_next) r_state <= S_SWEEP;
          else                  r_state <= S_WAIT;
        end
        S_SWEEP: begin
          r_mask <= r_mask | w_idx_onehot;
          if (w_last) r_state <= S_LOSE;
          else        r_idx   <= r_idx + LEN_W'(1);
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Revealed characters: word characters where the mask is set, else zero.
  always_comb begin
    revealed = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (r_mask[i]) revealed[i*CHAR_W +: CHAR_W] = r_word[i*CHAR_W +: CHAR_W];
  end

  assign guess_ready   = (r_state == S_WAIT) && !new_game;
  assign result_valid  = (r_state == S_RESOLVE);
  assign result_code   = result_valid ? w_code : 2'b00;
  assign revealed_mask = r_mask;
  assign missed        = r_missed;
  assign miss_count    = r_miss_count;
  assign win           = (r_state == S_WIN);
  assign lose          = (r_state == S_LOSE);
  assign busy          = (r_state == S_SCAN) || (r_state == S_RESOLVE) || (r_state == S_SWEEP);
  assign dbg_state     = r_state;

endmodule

// File: doc/hangman_engine.md
Name: hangman_engine

Overview:
- Parametrised successor to the fixed 12-letter / 6-miss hangman controller.
- Holds one game at a time: the secret word, the per-position reveal mask, the missed-letter list and the miss counter.
- Accepts guesses through a valid/ready handshake, scans one word position per clock, and returns a one-cycle coded result.
- Adds repeat-guess detection with no penalty, rejection of the null character, in-place restart on `new_game`, and a sequential reveal-all sweep on a loss.

Parameters:
- MAX_LEN, 12: maximum word length in characters.
- CHAR_W, 8: character width in bits.
- MAX_MISSES, 6: misses that end the game (lose).
- LEN_W, $clog2(MAX_LEN+1): width of `length` (derived).
- MISS_W, $clog2(MAX_MISSES+1): width of `miss_count` (derived).

Ports:
- Clk, input, 1: system clock, rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- new_game, input, 1: one-cycle pulse; latches `word` and `length` and clears all game state.
- word, input, MAX_LEN*CHAR_W: secret word; character i is at [i*CHAR_W +: CHAR_W].
- length, input, LEN_W: number of valid characters in `word`.
- guess_valid, input, 1: a guess is offered this cycle.
- guess, input, CHAR_W: guessed character.
- guess_ready, output, 1: the engine accepts a guess this cycle.
- result_valid, output, 1: one-cycle pulse marking `result_code` as valid.
- result_code, output, 2: 00 HIT, 01 MISS, 10 REPEAT, 11 REJECT.
- revealed, output, MAX_LEN*CHAR_W: word characters where the mask bit is set, 0 elsewhere.
- revealed_mask, output, MAX_LEN: per-position reveal flags.
- missed, output, MAX_MISSES*CHAR_W: missed letters in order; slot k = k-th miss.
- miss_count, output, MISS_W: misses so far; also drives the body-part display.
- win, lose, output, 1 each: terminal flags, held until `new_game` or reset.
- busy, output, 1: a scan or a reveal sweep is in progress.

Behaviour:
- Reset (async, Reset=0):
  - State IDLE.
  - All outputs 0, including `guess_ready`, `revealed_mask`, `missed`, `miss_count`, `win`, `lose`.
  - Latched word and length cleared.
- States: IDLE, WAIT, SCAN, RESOLVE, SWEEP, WIN, LOSE.
- `new_game` takes priority over everything, in any state:
  - Next state is WAIT.
  - Word and length are latched; mask, `missed`, `miss_count`, `win`, `lose` and `busy` are cleared.
  - An in-flight scan or sweep is aborted with no `result_valid`.
  - If the latched length is 0 or greater than MAX_LEN, next state is IDLE instead and no game starts.
- Handshake:
  - `guess_ready = (state==WAIT) && !new_game`.
  - A transfer occurs when `guess_valid && guess_ready`.
  - The guess is latched on the transfer edge.
  - `guess_valid` while not ready is ignored and not queued.
- Accept cycle:
  - If `guess` is 0: go to RESOLVE with REJECT.
  - Otherwise: go to SCAN with index 0 and the hit/new/repeat flags cleared.
  - At the same time, compare `guess` with the first `miss_count` slots of `missed`. A match sets the repeat flag.
- SCAN visits one position per clock, i = 0 .. length-1. When `word[i]` equals the latched guess:
  - If `mask[i]` is already 1: set the repeat flag.
  - Otherwise: set `mask[i]` and the new flag.
  - Every occurrence is revealed, not only the first.
- Leave SCAN after i = length-1, then go to RESOLVE.
- RESOLVE (one cycle) asserts `result_valid` with `result_code` chosen by priority:
  - REJECT, if flagged on accept;
  - else HIT, if the new flag is set;
  - else REPEAT, if the repeat flag is set;
  - else MISS.
- On MISS in RESOLVE:
  - The guess is written to slot `miss_count`.
  - `miss_count` increments.
- Next state after RESOLVE:
  - WIN, if all of mask[length-1:0] are set;
  - else SWEEP, if the post-increment `miss_count` equals MAX_MISSES;
  - else WAIT.
- Latency:
  - Accept edge at T gives `result_valid` at T+length+1.
  - A REJECT gives `result_valid` at T+1.
- SWEEP:
  - Sets `mask[i]` one position per clock, i = 0 .. length-1.
  - `busy` = 1 during SWEEP; then go to LOSE.
- WIN asserts `win` and LOSE asserts `lose`. Both are held, with `guess_ready` = 0.
- `win` and `lose` are never 1 at the same time. Win is evaluated before lose, so a HIT that completes the word on the final allowed guess wins.
- `busy` = 1 in SCAN, RESOLVE and SWEEP.
- Positions at index ≥ length are never revealed and always read 0.
- `revealed` is combinational from the mask and the latched word.
- Unused `missed` slots read 0.
- `miss_count` saturates at MAX_MISSES.

Test Plan:
- **HIT, all occurrences:** reset, `new_game` with "HELLO", length=5; guess 'L' → `result_valid` 6 cycles after accept, code 00, `revealed_mask` = 5'b01100, `revealed[23:16]` = 'L', `revealed[31:24]` = 'L'.
- **REPEAT on hit letter:** same game, guess 'L' again → code 10, mask unchanged, `miss_count` = 0.
- **MISS then REPEAT miss:** guess 'Z' → code 01, `missed[7:0]` = 'Z', `miss_count` = 1; guess 'Z' again → code 10, `miss_count` stays 1.
- **Lose path:** 6 distinct wrong letters (A, B, C, D, F, G) on "HELLO" → 6th gives code 01, `miss_count` = 6, `busy` high for 5 SWEEP cycles, `revealed_mask` = 5'h1F, `lose` = 1, `win` = 0, `guess_ready` = 0.
- **Win path:** guesses H, E, L, O → final code 00, next cycle `win` = 1; a further `guess_valid` is not accepted.
- **Abort and reject:** assert `new_game` 2 cycles into a SCAN → no `result_valid`, mask = 0, `guess_ready` = 1 the next cycle; guess 0x00 → code 11 one cycle after accept; `new_game` with length=0 → IDLE, `guess_ready` = 0. Async Reset mid-SWEEP → all outputs 0 immediately.
